// File: rtl/song_pkg.sv
// Shared definitions for the song sequencer: FSM states, the release scan code,
// and the pitch/duration decoders applied to each note-table byte.
package song_pkg;

    localparam logic [7:0] KEY_RELEASE = 8'hF0;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_PRESS   = 3'd2,
        ST_RELEASE = 3'd3,
        ST_ADVANCE = 3'd4
    } state_e;

    function automatic logic [7:0] pitch_code(input logic [3:0] code);
        logic [7:0] key;
        case (code)
            4'd1:    key = 8'h2B;
            4'd2:    key = 8'h34;
            4'd3:    key = 8'h33;
            4'd4:    key = 8'h3B;
            4'd5:    key = 8'h42;
            4'd6:    key = 8'h4B;
            4'd7:    key = 8'h4C;
            4'd8:    key = 8'h4A;
            4'd9:    key = 8'h4D;
            4'd10:   key = 8'h4E;
            4'd11:   key = 8'h4F;
            4'd12:   key = 8'h50;
            4'd13:   key = 8'h51;
            4'd14:   key = 8'h52;
            default: key = KEY_RELEASE;
        endcase
        return key;
    endfunction

    function automatic logic [8:0] dur_units(input logic [3:0] code);
        logic [8:0] units;
        case (code)
            4'hF:    units = 9'h010;
            4'h8:    units = 9'h020;
            4'hA:    units = 9'h028;
            4'h9:    units = 9'h030;
            4'h1:    units = 9'h040;
            4'h3:    units = 9'h060;
            4'h2:    units = 9'h080;
            4'hB:    units = 9'h0C8;
            4'h4:    units = 9'h100;
            default: units = 9'h000;
        endcase
        return units;
    endfunction

endpackage

// File: rtl/song_note_ram.sv
// DEPTH x 8 note table: one write port, one registered read port, read-first.
// Contents are deliberately not reset.
module song_note_ram #(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clock,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data
);

    logic [7:0] mem [DEPTH];

    // Write and read on the same edge; the read sees the pre-write contents.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/song_sequencer.sv
// Plays a stored note table as keyboard scan codes (press for the note length,
// then a release gap). Optional pause input enabled by SONG_SEQ_PAUSE_EN.
module song_sequencer
    import song_pkg::*;
#(
    parameter int DEPTH    = 16,
    parameter int TICK_DIV = 1,
    parameter int GAP      = 2
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       stop,
    input  logic                       loop_en,
    input  logic [$clog2(DEPTH):0]     song_len,
    input  logic                       wr_en,
    input  logic [$clog2(DEPTH)-1:0]   wr_addr,
    input  logic [7:0]                 wr_data,
`ifdef SONG_SEQ_PAUSE_EN
    input  logic                       pause,
`endif
    output logic [7:0]                 key_code,
    output logic                       key_valid,
    output logic                       busy,
    output logic                       done,
    output logic [$clog2(DEPTH)-1:0]   step
);

    localparam int AW    = $clog2(DEPTH);
    localparam int LEN_W = AW + 1;
    localparam logic [LEN_W-1:0] DEPTH_LEN = LEN_W'(DEPTH);
    localparam logic [24:0]      TICKS     = 25'(TICK_DIV);
    localparam logic [24:0]      GAP_LAST  = 25'(GAP - 1);

    state_e            state, state_nxt;
    logic [AW-1:0]     step_nxt;
    logic [LEN_W-1:0]  len_r, len_nxt;
    logic [24:0]       cnt, cnt_nxt;
    logic [7:0]        pitch_r, pitch_nxt, key_nxt;
    logic              done_nxt;
    logic [7:0]        rd_data;
    logic              hold;
    logic [24:0]       fetch_ticks;

`ifdef SONG_SEQ_PAUSE_EN
    assign hold = pause && (state != ST_IDLE);
`else
    assign hold = 1'b0;
`endif

    assign fetch_ticks = {16'd0, dur_units(rd_data[7:4])} * TICKS;

    // The table is addressed by the upcoming step so the note is ready during FETCH.
    song_note_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
        .clock   (clock),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (step_nxt),
        .rd_data (rd_data)
    );

    // Next-state logic; stop wins over pause, pause freezes everything else.
    always_comb begin
        state_nxt = state;
        step_nxt  = step;
        len_nxt   = len_r;
        cnt_nxt   = cnt;
        pitch_nxt = pitch_r;
        done_nxt  = 1'b0;
        if (stop && (state != ST_IDLE)) begin
            state_nxt = ST_IDLE;
            step_nxt  = '0;
            cnt_nxt   = '0;
        end else if (hold) begin
            state_nxt = state;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start && !stop && (song_len != '0)) begin
                        state_nxt = ST_FETCH;
                        step_nxt  = '0;
                        len_nxt   = (song_len > DEPTH_LEN) ? DEPTH_LEN : song_len;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
                ST_FETCH: begin
                    pitch_nxt = pitch_code(rd_data[3:0]);
                    if (fetch_ticks == 25'd0) begin
                        state_nxt = ST_RELEASE;
                        cnt_nxt   = GAP_LAST;
                    end else begin
                        state_nxt = ST_PRESS;
                        cnt_nxt   = fetch_ticks - 25'd1;
                    end
                end
                ST_PRESS: begin
                    if (cnt == 25'd0) begin
                        state_nxt = ST_RELEASE;
                        cnt_nxt   = GAP_LAST;
                    end else begin
                        cnt_nxt = cnt - 25'd1;
                    end
                end
                ST_RELEASE: begin
                    if (cnt == 25'd0) begin
                        state_nxt = ST_ADVANCE;
                    end else begin
                        cnt_nxt = cnt - 25'd1;
                    end
                end
                ST_ADVANCE: begin
                    if ((LEN_W'(step) + LEN_W'(1)) < len_r) begin
                        step_nxt  = step + AW'(1);
                        state_nxt = ST_FETCH;
                    end else if (loop_en) begin
                        step_nxt  = '0;
                        state_nxt = ST_FETCH;
                    end else begin
                        step_nxt  = '0;
                        state_nxt = ST_IDLE;
                        done_nxt  = 1'b1;
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                    step_nxt  = '0;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    // Scan code shown in the coming cycle: the pitch only while actively pressing.
    always_comb begin
        if ((state_nxt == ST_PRESS) && !hold) begin
            key_nxt = pitch_nxt;
        end else begin
            key_nxt = KEY_RELEASE;
        end
    end

    // State and registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            step      <= '0;
            len_r     <= '0;
            cnt       <= '0;
            pitch_r   <= KEY_RELEASE;
            key_code  <= KEY_RELEASE;
            key_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            step      <= step_nxt;
            len_r     <= len_nxt;
            cnt       <= cnt_nxt;
            pitch_r   <= pitch_nxt;
            key_code  <= key_nxt;
            key_valid <= (key_nxt != key_code);
            busy      <= (state_nxt != ST_IDLE);
            done      <= done_nxt;
        end
    end

endmodule

// File: tb/tb_song_sequencer.sv
// Self-checking bench: a per-cycle expectation queue built from the note table
// is compared with the DUT outputs on every falling edge.
module tb_song_sequencer;

    localparam int DEPTH = 16;
    localparam int TD    = 1;
    localparam int GP    = 2;

    logic       clock;
    logic       reset;
    logic       start;
    logic       stop;
    logic       loop_en;
    logic [4:0] song_len;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
`ifdef SONG_SEQ_PAUSE_EN
    logic       pause;
`endif
    logic [7:0] key_code;
    logic       key_valid;
    logic       busy;
    logic       done;
    logic [3:0] step;

    song_sequencer #(.DEPTH(DEPTH), .TICK_DIV(TD), .GAP(GP)) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .stop      (stop),
        .loop_en   (loop_en),
        .song_len  (song_len),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
`ifdef SONG_SEQ_PAUSE_EN
        .pause     (pause),
`endif
        .key_code  (key_code),
        .key_valid (key_valid),
        .busy      (busy),
        .done      (done),
        .step      (step)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic [7:0] key;
        logic       bsy;
        logic       dn;
        logic [3:0] stp;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] table_m [DEPTH];
    int         nvec = 0;
    int         nerr = 0;
    int         n_done = 0;
    int         n_valid = 0;
    int         n_42 = 0;
    logic [7:0] prev_key = 8'hF0;

    function automatic logic [7:0] m_pitch(input int c);
        case (c)
            1: return 8'h2B;   2: return 8'h34;   3: return 8'h33;   4: return 8'h3B;
            5: return 8'h42;   6: return 8'h4B;   7: return 8'h4C;   8: return 8'h4A;
            9: return 8'h4D;   10: return 8'h4E;  11: return 8'h4F;  12: return 8'h50;
            13: return 8'h51;  14: return 8'h52;
            default: return 8'hF0;
        endcase
    endfunction

    function automatic int m_units(input int c);
        case (c)
            15: return 16;  8: return 32;  10: return 40;  9: return 48;  1: return 64;
            3: return 96;   2: return 128; 11: return 200; 4: return 256;
            default: return 0;
        endcase
    endfunction

    task automatic push(input logic [7:0] k, input logic b, input logic d, input int s, input int n);
        exp_t e;
        e = '{key: k, bsy: b, dn: d, stp: 4'(s)};
        for (int i = 0; i < n; i++) exp_q.push_back(e);
    endtask

    // Expected cycles of a whole song, starting with the cycle after start is taken.
    task automatic model_play(input int len, input bit loop, input int passes);
        int nl;
        nl = (len > DEPTH) ? DEPTH : len;
        for (int p = 0; p < passes; p++) begin
            for (int i = 0; i < nl; i++) begin
                int u;
                u = m_units(int'(table_m[i][7:4]));
                push(8'hF0, 1'b1, 1'b0, i, 1);
                if (u > 0) push(m_pitch(int'(table_m[i][3:0])), 1'b1, 1'b0, i, u * TD);
                push(8'hF0, 1'b1, 1'b0, i, GP);
                push(8'hF0, 1'b1, 1'b0, i, 1);
            end
        end
        if (!loop) push(8'hF0, 1'b0, 1'b1, 0, 1);
    endtask

    // Per-cycle comparison of every output against the expectation queue.
    always @(negedge clock) begin
        exp_t e;
        logic ev;
        if (reset || exp_q.size() == 0) begin
            e = '{key: 8'hF0, bsy: 1'b0, dn: 1'b0, stp: 4'd0};
            if (reset) begin
                prev_key = 8'hF0;
                exp_q.delete();
            end
        end else begin
            e = exp_q.pop_front();
        end
        ev = reset ? 1'b0 : (e.key != prev_key);
        prev_key = e.key;
        nvec++;
        if ({key_code, key_valid, busy, done, step} !== {e.key, ev, e.bsy, e.dn, e.stp}) begin
            nerr++;
            $display("FAIL cycle t=%0t got key=%h valid=%b busy=%b done=%b step=%0d expected key=%h valid=%b busy=%b done=%b step=%0d",
                     $time, key_code, key_valid, busy, done, step, e.key, ev, e.bsy, e.dn, e.stp);
        end
        if (key_code == 8'h42) n_42++;
        if (done) n_done++;
        if (key_valid) n_valid++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input int act, input int expv);
        nvec++;
        if (act !== expv) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    task automatic write_tab(input int a, input logic [7:0] d);
        wr_en = 1'b1;
        wr_addr = 4'(a);
        wr_data = d;
        table_m[a] = d;
        tick(1);
        wr_en = 1'b0;
    endtask

    task automatic do_start(input int len, input bit loop, input int passes);
        start = 1'b1;
        song_len = 5'(len);
        loop_en = loop;
        push(8'hF0, 1'b0, 1'b0, 0, 1);
        model_play(len, loop, passes);
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 5000 && exp_q.size() != 0; i++) tick(1);
        check({name, "_timeout"}, exp_q.size(), 0);
    endtask

    task automatic clear_tally();
        n_done = 0;
        n_valid = 0;
        n_42 = 0;
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        stop = 1'b0;
        loop_en = 1'b0;
        song_len = 5'd0;
        wr_en = 1'b0;
        wr_addr = 4'd0;
        wr_data = 8'd0;
`ifdef SONG_SEQ_PAUSE_EN
        pause = 1'b0;
`endif
        for (int i = 0; i < DEPTH; i++) table_m[i] = 8'h00;
        tick(3);
        reset = 1'b0;
        tick(2);

        check("model_pitch5", int'(m_pitch(5)), 8'h42);
        check("model_pitch15_rest", int'(m_pitch(15)), 8'hF0);
        check("model_units8", m_units(8), 32);
        check("model_unitsB", m_units(11), 200);
        check("model_units4", m_units(4), 256);

        // single note 85
        for (int i = 0; i < DEPTH; i++) write_tab(i, 8'h00);
        write_tab(0, 8'h85);
        clear_tally();
        do_start(1, 1'b0, 1);
        wait_idle("single");
        tick(2);
        check("single_42_cycles", n_42, 32);
        check("single_done_pulses", n_done, 1);
        check("single_valid_strobes", n_valid, 2);

        // four-note song with a rest
        write_tab(1, 8'hF0);
        write_tab(2, 8'h84);
        write_tab(3, 8'hB5);
        clear_tally();
        do_start(4, 1'b0, 1);
        wait_idle("song4");
        tick(2);
        check("song4_done_pulses", n_done, 1);
        check("song4_valid_strobes", n_valid, 6);
        check("song4_42_cycles", n_42, 232);

        // looping two notes, then stop mid-way
        clear_tally();
        do_start(2, 1'b1, 3);
        tick(130);
        stop = 1'b1;
        while (exp_q.size() > 1) void'(exp_q.pop_back());
        tick(1);
        stop = 1'b0;
        tick(3);
        check("loop_no_done", n_done, 0);
        check("loop_stopped_busy", int'(busy), 0);
        loop_en = 1'b0;

        // start+stop together, and zero length: both ignored
        start = 1'b1; stop = 1'b1; song_len = 5'd1;
        tick(1);
        start = 1'b0; stop = 1'b0;
        song_len = 5'd0; start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(3);
        check("ignored_starts_busy", int'(busy), 0);

        // zero-duration note: only the release gap
        write_tab(0, 8'h05);
        clear_tally();
        do_start(1, 1'b0, 1);
        wait_idle("zero_dur");
        check("zero_dur_valid", n_valid, 0);

        // clamped length, with a same-edge write to the first entry
        for (int i = 0; i < DEPTH; i++) write_tab(i, {4'hF, 4'(i)});
        start = 1'b1;
        song_len = 5'd20;
        loop_en = 1'b0;
        wr_en = 1'b1; wr_addr = 4'd0; wr_data = 8'h0A;
        push(8'hF0, 1'b0, 1'b0, 0, 1);
        model_play(20, 1'b0, 1);
        table_m[0] = 8'h0A;
        tick(1);
        start = 1'b0; wr_en = 1'b0;
        wait_idle("clamp");

        // long note, reset mid-press
        write_tab(0, 8'h45);
        do_start(1, 1'b0, 1);
        tick(99);
        reset = 1'b1;
        #1;
        check("async_reset_key", int'(key_code), 8'hF0);
        check("async_reset_busy", int'(busy), 0);
        tick(2);
        reset = 1'b0;
        tick(2);

        // table survives reset
        clear_tally();
        do_start(1, 1'b0, 1);
        wait_idle("after_reset");
        check("after_reset_42_cycles", n_42, 256);

`ifdef SONG_SEQ_PAUSE_EN
        write_tab(0, 8'h85);
        clear_tally();
        do_start(1, 1'b0, 1);
        tick(10);
        pause = 1'b1;
        for (int i = 0; i < 10; i++) exp_q.insert(1, '{key: 8'hF0, bsy: 1'b1, dn: 1'b0, stp: 4'd0});
        tick(10);
        pause = 1'b0;
        wait_idle("pause");
        check("pause_42_cycles", n_42, 32);
`endif

        tick(3);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
